// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses the combinational
// instruction memory and captures the returned word into IF/ID.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MEM_WORDS = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_instr_i,
  output logic [31:0] pc_o,
  output logic [31:0] ifid_pc_plus4_o,
  output logic [31:0] ifid_instr_o,
  output logic        ifid_valid_o,
  output logic        addr_err_o,
  output logic [31:0] fetch_cnt_o
);

  // Byte limit held in 34 bits so MEM_WORDS*4 == 2^32 does not wrap to zero.
  localparam logic [33:0] LIMIT = 34'(MEM_WORDS) << 2;

  logic [31:0] r_pc;
  logic [31:0] r_ifid_pc_plus4;
  logic [31:0] r_ifid_instr;
  logic        r_ifid_valid;
  logic        r_addr_err;
  logic [31:0] r_fetch_cnt;

  logic [31:0] w_pc_plus4;
  logic        w_in_range;

  // Sequential PC increment and full-width range test on the current PC.
  always_comb begin
    w_pc_plus4 = r_pc + 32'd4;
    w_in_range = ({2'b00, r_pc} < LIMIT);
  end

  // PC and IF/ID update, priority: reset > redirect > stall > out-of-range > normal.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pc            <= RESET_PC;
      r_ifid_pc_plus4 <= '0;
      r_ifid_instr    <= '0;
      r_ifid_valid    <= 1'b0;
      r_addr_err      <= 1'b0;
      r_fetch_cnt     <= '0;
    end else if (redirect_i) begin
      r_pc            <= redirect_pc_i & ~32'h0000_0003;
      r_ifid_pc_plus4 <= '0;
      r_ifid_instr    <= '0;
      r_ifid_valid    <= 1'b0;
    end else if (stall_i) begin
      r_pc            <= r_pc;
    end else if (!w_in_range) begin
      r_ifid_pc_plus4 <= '0;
      r_ifid_instr    <= '0;
      r_ifid_valid    <= 1'b0;
      r_addr_err      <= 1'b1;
    end else begin
      r_pc            <= w_pc_plus4;
      r_ifid_pc_plus4 <= w_pc_plus4;
      r_ifid_instr    <= imem_instr_i;
      r_ifid_valid    <= 1'b1;
      r_fetch_cnt     <= r_fetch_cnt + 32'd1;
    end
  end

  // Outputs come straight from registers; only the memory address mirrors the PC.
  always_comb begin
    imem_addr_o     = r_pc;
    pc_o            = r_pc;
    ifid_pc_plus4_o = r_ifid_pc_plus4;
    ifid_instr_o    = r_ifid_instr;
    ifid_valid_o    = r_ifid_valid;
    addr_err_o      = r_addr_err;
    fetch_cnt_o     = r_fetch_cnt;
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Scoreboard bench for if_fetch_stage: directed steps push hand-computed
// post-edge expectations; a negedge monitor pops and compares them.
module tb_if_fetch_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A: default build (RESET_PC=0, MEM_WORDS=32)
  logic        rst_a, stall_a, redir_a;
  logic [31:0] rpc_a, addr_a, instr_a, pc_a, p4_a, ii_a, cnt_a;
  logic        v_a, err_a;

  // DUT B: wrap build (RESET_PC at top of address space, in range)
  logic        rst_b, stall_b, redir_b;
  logic [31:0] rpc_b, addr_b, instr_b, pc_b, p4_b, ii_b, cnt_b;
  logic        v_b, err_b;

  if_fetch_stage #(.RESET_PC(32'h0000_0000), .MEM_WORDS(32)) u_dut_a (
    .clk_i(clk), .rst_i(rst_a), .stall_i(stall_a), .redirect_i(redir_a),
    .redirect_pc_i(rpc_a), .imem_addr_o(addr_a), .imem_instr_i(instr_a),
    .pc_o(pc_a), .ifid_pc_plus4_o(p4_a), .ifid_instr_o(ii_a),
    .ifid_valid_o(v_a), .addr_err_o(err_a), .fetch_cnt_o(cnt_a)
  );

  if_fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .MEM_WORDS(32'd1073741824)) u_dut_b (
    .clk_i(clk), .rst_i(rst_b), .stall_i(stall_b), .redirect_i(redir_b),
    .redirect_pc_i(rpc_b), .imem_addr_o(addr_b), .imem_instr_i(instr_b),
    .pc_o(pc_b), .ifid_pc_plus4_o(p4_b), .ifid_instr_o(ii_b),
    .ifid_valid_o(v_b), .addr_err_o(err_b), .fetch_cnt_o(cnt_b)
  );

  // Instruction memory model: words 0..3 are 0x11..0x44, others tagged by index.
  function automatic logic [31:0] memword(input logic [31:0] addr);
    logic [31:0] idx;
    idx = addr >> 2;
    if (addr >= 32'd128) return 32'hBAD0_BAD0;
    if (idx < 4) return 32'h11 * (idx + 1);
    return 32'hA000_0000 | idx;
  endfunction

  always_comb instr_a = memword(addr_a);
  assign instr_b = 32'h5A5A_0001;

  typedef struct {
    bit          sel_b;
    string       tag;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] p4;
    logic        valid;
    logic        err;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb[$];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  function automatic void chk(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endfunction

  // Monitor: compare every expectation queued for the edge just passed.
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      if (e.sel_b) begin
        chk({e.tag, ".pc"},    pc_b,   e.pc);
        chk({e.tag, ".addr"},  addr_b, e.pc);
        chk({e.tag, ".instr"}, ii_b,   e.instr);
        chk({e.tag, ".p4"},    p4_b,   e.p4);
        chk({e.tag, ".valid"}, {31'd0, v_b},   {31'd0, e.valid});
        chk({e.tag, ".err"},   {31'd0, err_b}, {31'd0, e.err});
        chk({e.tag, ".cnt"},   cnt_b,  e.cnt);
      end else begin
        chk({e.tag, ".pc"},    pc_a,   e.pc);
        chk({e.tag, ".addr"},  addr_a, e.pc);
        chk({e.tag, ".instr"}, ii_a,   e.instr);
        chk({e.tag, ".p4"},    p4_a,   e.p4);
        chk({e.tag, ".valid"}, {31'd0, v_a},   {31'd0, e.valid});
        chk({e.tag, ".err"},   {31'd0, err_a}, {31'd0, e.err});
        chk({e.tag, ".cnt"},   cnt_a,  e.cnt);
      end
    end
  end

  task automatic push(input bit selb, input string tag, input logic [31:0] pc,
                      input logic [31:0] ins, input logic [31:0] p4,
                      input logic v, input logic er, input logic [31:0] cnt);
    exp_t e;
    e.sel_b = selb; e.tag = tag; e.pc = pc; e.instr = ins; e.p4 = p4;
    e.valid = v; e.err = er; e.cnt = cnt;
    sb.push_back(e);
  endtask

  // One clock of stimulus on DUT A plus the expected state after that edge.
  task automatic step(input string tag, input logic r, input logic s,
                      input logic rd, input logic [31:0] rpc,
                      input logic [31:0] pc, input logic [31:0] ins,
                      input logic [31:0] p4, input logic v, input logic er,
                      input logic [31:0] cnt);
    rst_a = r; stall_a = s; redir_a = rd; rpc_a = rpc;
    @(posedge clk);
    #1;
    push(1'b0, tag, pc, ins, p4, v, er, cnt);
  endtask

  // DUT B: reset to 0xFFFF_FFFC, then two normal fetches across the wrap.
  initial begin
    rst_b = 1'b1; stall_b = 1'b0; redir_b = 1'b0; rpc_b = '0;
    @(posedge clk); #1;
    push(1'b1, "wrap_rst", 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);
    rst_b = 1'b0;
    @(posedge clk); #1;
    push(1'b1, "wrap_1", 32'h0, 32'h5A5A_0001, 32'h0, 1'b1, 1'b0, 32'd1);
    @(posedge clk); #1;
    push(1'b1, "wrap_2", 32'h4, 32'h5A5A_0001, 32'h4, 1'b1, 1'b0, 32'd2);
    rst_b = 1'b1;
  end

  initial begin
    //   tag          rst stl rdr rpc            pc            instr         p4            v  err cnt
    step("reset",     1, 0, 0, 32'h0,  32'h00, 32'h00,       32'h00, 0, 0, 0);
    step("run1",      0, 0, 0, 32'h0,  32'h04, 32'h11,       32'h04, 1, 0, 1);
    step("run2",      0, 0, 0, 32'h0,  32'h08, 32'h22,       32'h08, 1, 0, 2);
    step("run3",      0, 0, 0, 32'h0,  32'h0C, 32'h33,       32'h0C, 1, 0, 3);
    step("run4",      0, 0, 0, 32'h0,  32'h10, 32'h44,       32'h10, 1, 0, 4);
    step("reset2",    1, 0, 0, 32'h0,  32'h00, 32'h00,       32'h00, 0, 0, 0);
    step("pre_stl1",  0, 0, 0, 32'h0,  32'h04, 32'h11,       32'h04, 1, 0, 1);
    step("pre_stl2",  0, 0, 0, 32'h0,  32'h08, 32'h22,       32'h08, 1, 0, 2);
    for (int i = 0; i < 3; i++)
      step("stall",   0, 1, 0, 32'h0,  32'h08, 32'h22,       32'h08, 1, 0, 2);
    step("release",   0, 0, 0, 32'h0,  32'h0C, 32'h33,       32'h0C, 1, 0, 3);
    step("redir_stl", 0, 1, 1, 32'h17, 32'h14, 32'h00,       32'h00, 0, 0, 3);
    step("after_rd",  0, 0, 0, 32'h0,  32'h18, 32'hA000_0005, 32'h18, 1, 0, 4);
    step("redir_74",  0, 0, 1, 32'h74, 32'h74, 32'h00,       32'h00, 0, 0, 4);
    step("w29",       0, 0, 0, 32'h0,  32'h78, 32'hA000_001D, 32'h78, 1, 0, 5);
    step("w30",       0, 0, 0, 32'h0,  32'h7C, 32'hA000_001E, 32'h7C, 1, 0, 6);
    step("w31",       0, 0, 0, 32'h0,  32'h80, 32'hA000_001F, 32'h80, 1, 0, 7);
    step("oor1",      0, 0, 0, 32'h0,  32'h80, 32'h00,       32'h00, 0, 1, 7);
    step("oor2",      0, 0, 0, 32'h0,  32'h80, 32'h00,       32'h00, 0, 1, 7);
    step("oor_stall", 0, 1, 0, 32'h0,  32'h80, 32'h00,       32'h00, 0, 1, 7);
    step("resume_rd", 0, 0, 1, 32'h0,  32'h00, 32'h00,       32'h00, 0, 1, 7);
    step("resume",    0, 0, 0, 32'h0,  32'h04, 32'h11,       32'h04, 1, 1, 8);
    step("redir_1c",  0, 0, 1, 32'h1F, 32'h1C, 32'h00,       32'h00, 0, 1, 8);
    step("w7",        0, 0, 0, 32'h0,  32'h20, 32'hA000_0007, 32'h20, 1, 1, 9);
    step("stall_20",  0, 1, 0, 32'h0,  32'h20, 32'hA000_0007, 32'h20, 1, 1, 9);
    step("rst_stall", 1, 1, 0, 32'h0,  32'h00, 32'h00,       32'h00, 0, 0, 0);
    step("post_rst",  0, 0, 0, 32'h0,  32'h04, 32'h11,       32'h04, 1, 0, 1);
    step("rst_redir", 1, 0, 1, 32'h40, 32'h00, 32'h00,       32'h00, 0, 0, 0);
    step("post_rst2", 0, 0, 0, 32'h0,  32'h04, 32'h11,       32'h04, 1, 0, 1);

    // Drain: the monitor must have consumed everything within a few cycles.
    for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk);
    #1;
    n_checks++;
    if (sb.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d pending expected 0", sb.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
Instruction-fetch stage of the pipelined CPU. Owns the program counter, drives the address into the combinational instruction memory, and captures the returned word into the IF/ID pipeline register. Supports a hazard-unit stall, a branch/jump redirect with flush, and out-of-range fetch detection. It sits directly upstream of the instruction memory and feeds the decode stage.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
MEM_WORDS, 32, depth of the instruction memory in 32-bit words; the legal fetch range is 0 .. MEM_WORDS*4-4.

Ports:
clk_i  input  1  system clock; all state updates on the rising edge
rst_i  input  1  synchronous, active-high reset
stall_i  input  1  hazard-unit stall: hold PC and IF/ID
redirect_i  input  1  taken branch/jump: load new PC and flush IF/ID
redirect_pc_i  input  32  redirect target byte address
imem_addr_o  output  32  byte address to instruction memory; equals pc_o, combinational
imem_instr_i  input  32  instruction word from memory, same cycle as imem_addr_o
pc_o  output  32  current PC register
ifid_pc_plus4_o  output  32  IF/ID: PC+4 of the captured instruction
ifid_instr_o  output  32  IF/ID: captured instruction; 32'h0 (NOP) when invalid
ifid_valid_o  output  1  IF/ID holds a real fetched instruction
addr_err_o  output  1  sticky flag: a fetch was attempted outside the legal range
fetch_cnt_o  output  32  count of instructions loaded into IF/ID since reset

Behaviour:
- Reset (rst_i=1 at clock edge): pc<=RESET_PC; ifid_pc_plus4<=0; ifid_instr<=0; ifid_valid<=0; addr_err<=0; fetch_cnt<=0. Reset overrides every other input.
- in_range = (pc < MEM_WORDS*4). Compare on the full 32 bits.
- Per-cycle priority, highest first: reset > redirect > stall > out-of-range > normal.
- Redirect (redirect_i=1, whether or not stall_i=1): pc<={redirect_pc_i[31:2],2'b00}, so the low bits are forced aligned. IF/ID is flushed: instr<=0, pc_plus4<=0, valid<=0. fetch_cnt does not change.
- Stall (stall_i=1, redirect_i=0): pc, IF/ID and fetch_cnt all hold.
- Out-of-range (not stalled, no redirect, !in_range): pc holds, so fetch halts. IF/ID loads a bubble: instr<=0, pc_plus4<=0, valid<=0. addr_err<=1. Fetch resumes only after a redirect to a legal address. addr_err clears only on reset.
- Normal: pc<=pc+4, using 32-bit modulo arithmetic (32'hFFFF_FFFC wraps to 0). IF/ID loads instr<=imem_instr_i, pc_plus4<=pc+4, valid<=1. fetch_cnt<=fetch_cnt+1, wrapping at 2^32.
- Latency: the word addressed in cycle N appears on the ifid_* outputs after edge N+1.
- No combinational path from stall_i or redirect_i to any output.
- The PC register always holds an aligned value; imem_addr_o is pc.
- Reset asserted mid-stall or mid-redirect: reset wins, and the next cycle fetches from RESET_PC.

Test Plan:
- Reset then 4 free-running cycles with memory words 0x11,0x22,0x33,0x44 -> pc_o steps 0,4,8,12,16. ifid_instr_o is 0x11..0x44 on successive cycles, with ifid_pc_plus4_o 4,8,12,16 and valid=1. fetch_cnt_o reaches 4.
- Stall for 3 cycles while pc=8 -> pc_o stays 8, ifid_instr_o stays 0x22, fetch_cnt_o is unchanged. After release, the next edge loads 0x33 and pc becomes 12.
- Redirect with redirect_pc_i=0x0000_0017 while stall_i=1 -> pc_o becomes 0x14. Next cycle ifid_instr_o=0, valid=0, fetch_cnt_o unchanged. The following edge loads word 5.
- With MEM_WORDS=32, run to pc=0x7C then 0x80 -> word 31 is loaded valid. At pc=0x80, pc holds, IF/ID shows a bubble, and addr_err_o=1. A redirect to 0x0 resumes fetch while addr_err_o stays 1.
- Set RESET_PC=32'hFFFF_FFFC with MEM_WORDS large enough to make it in-range (test build) -> after one normal cycle pc_o=0 and ifid_pc_plus4_o=0.
- Assert rst_i during a stall at pc=0x20 with addr_err_o=1 -> after the edge pc_o=RESET_PC, all ifid_* outputs are 0, addr_err_o=0 and fetch_cnt_o=0.
